// File: rtl/fft16_pkg.sv
// fft16_pkg: shared widths and twiddle ROM for the 16-point radix-2 FFT.
// Twiddles are W16^k, k = 0..7, in Q2.14 (re, im).
package fft16_pkg;

    localparam int DW    = 24;
    localparam int TW    = 16;
    localparam int TFRAC = 14;
    localparam int NPT   = 16;
    localparam int NSTG  = 4;

    localparam logic signed [TW-1:0] TW_RE [8] = '{
        16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,
        16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137
    };

    localparam logic signed [TW-1:0] TW_IM [8] = '{
        16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137,
        -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270
    };

    function automatic logic [3:0] bitrev4(input logic [3:0] i);
        return {i[0], i[1], i[2], i[3]};
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly: combinational radix-2 DIT butterfly, A +/- W*B.
// Index 0 bypasses the multiplier so unit-weight paths stay exact.
module fft_butterfly
    import fft16_pkg::*;
#(
    parameter int TWI = 0
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic signed [DW-1:0] y0_re,
    output logic signed [DW-1:0] y0_im,
    output logic signed [DW-1:0] y1_re,
    output logic signed [DW-1:0] y1_im
);

    logic signed [DW-1:0] wb_re;
    logic signed [DW-1:0] wb_im;

    generate
        if (TWI == 0) begin : g_bypass
            assign wb_re = b_re;
            assign wb_im = b_im;
        end else begin : g_mul
            localparam int PW = DW + TW + 1;
            localparam logic signed [TW-1:0] WR = TW_RE[TWI[2:0]];
            localparam logic signed [TW-1:0] WI = TW_IM[TWI[2:0]];

            logic signed [PW-1:0] p_re;
            logic signed [PW-1:0] p_im;

            // Full-precision complex product before the Q2.14 rescale
            always_comb begin
                p_re = PW'(b_re) * PW'(WR) - PW'(b_im) * PW'(WI);
                p_im = PW'(b_re) * PW'(WI) + PW'(b_im) * PW'(WR);
            end

            // Arithmetic shift floors; the low 24 bits wrap naturally
            assign wb_re = DW'(p_re >>> TFRAC);
            assign wb_im = DW'(p_im >>> TFRAC);
        end
    endgenerate

    // Sum and difference wrap modulo 2^24, no saturation
    always_comb begin
        y0_re = a_re + wb_re;
        y0_im = a_im + wb_im;
        y1_re = a_re - wb_re;
        y1_im = a_im - wb_im;
    end

endmodule

// File: rtl/fft_1.sv
// fft_1: fully pipelined 16-point radix-2 DIT FFT, one transform per clock.
// Input bank samples bit-reversed data; one bank follows each of 4 stages.
module fft_1
    import fft16_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] butt16_real0,
    input  logic [DW-1:0] butt16_real1,
    input  logic [DW-1:0] butt16_real2,
    input  logic [DW-1:0] butt16_real3,
    input  logic [DW-1:0] butt16_real4,
    input  logic [DW-1:0] butt16_real5,
    input  logic [DW-1:0] butt16_real6,
    input  logic [DW-1:0] butt16_real7,
    input  logic [DW-1:0] butt16_real8,
    input  logic [DW-1:0] butt16_real9,
    input  logic [DW-1:0] butt16_real10,
    input  logic [DW-1:0] butt16_real11,
    input  logic [DW-1:0] butt16_real12,
    input  logic [DW-1:0] butt16_real13,
    input  logic [DW-1:0] butt16_real14,
    input  logic [DW-1:0] butt16_real15,
    input  logic [DW-1:0] butt16_imag0,
    input  logic [DW-1:0] butt16_imag1,
    input  logic [DW-1:0] butt16_imag2,
    input  logic [DW-1:0] butt16_imag3,
    input  logic [DW-1:0] butt16_imag4,
    input  logic [DW-1:0] butt16_imag5,
    input  logic [DW-1:0] butt16_imag6,
    input  logic [DW-1:0] butt16_imag7,
    input  logic [DW-1:0] butt16_imag8,
    input  logic [DW-1:0] butt16_imag9,
    input  logic [DW-1:0] butt16_imag10,
    input  logic [DW-1:0] butt16_imag11,
    input  logic [DW-1:0] butt16_imag12,
    input  logic [DW-1:0] butt16_imag13,
    input  logic [DW-1:0] butt16_imag14,
    input  logic [DW-1:0] butt16_imag15,
    output logic [DW-1:0] y0_real_fin,
    output logic [DW-1:0] y1_real_fin,
    output logic [DW-1:0] y2_real_fin,
    output logic [DW-1:0] y3_real_fin,
    output logic [DW-1:0] y4_real_fin,
    output logic [DW-1:0] y5_real_fin,
    output logic [DW-1:0] y6_real_fin,
    output logic [DW-1:0] y7_real_fin,
    output logic [DW-1:0] y8_real_fin,
    output logic [DW-1:0] y9_real_fin,
    output logic [DW-1:0] y10_real_fin,
    output logic [DW-1:0] y11_real_fin,
    output logic [DW-1:0] y12_real_fin,
    output logic [DW-1:0] y13_real_fin,
    output logic [DW-1:0] y14_real_fin,
    output logic [DW-1:0] y15_real_fin,
    output logic [DW-1:0] y0_imag_fin,
    output logic [DW-1:0] y1_imag_fin,
    output logic [DW-1:0] y2_imag_fin,
    output logic [DW-1:0] y3_imag_fin,
    output logic [DW-1:0] y4_imag_fin,
    output logic [DW-1:0] y5_imag_fin,
    output logic [DW-1:0] y6_imag_fin,
    output logic [DW-1:0] y7_imag_fin,
    output logic [DW-1:0] y8_imag_fin,
    output logic [DW-1:0] y9_imag_fin,
    output logic [DW-1:0] y10_imag_fin,
    output logic [DW-1:0] y11_imag_fin,
    output logic [DW-1:0] y12_imag_fin,
    output logic [DW-1:0] y13_imag_fin,
    output logic [DW-1:0] y14_imag_fin,
    output logic [DW-1:0] y15_imag_fin
);

    logic signed [DW-1:0] x_re [NPT];
    logic signed [DW-1:0] x_im [NPT];

    logic signed [DW-1:0] bf_re [NSTG][NPT];
    logic signed [DW-1:0] bf_im [NSTG][NPT];

    logic signed [DW-1:0] pipe_re_d [NSTG+1][NPT];
    logic signed [DW-1:0] pipe_im_d [NSTG+1][NPT];
    logic signed [DW-1:0] pipe_re_q [NSTG+1][NPT];
    logic signed [DW-1:0] pipe_im_q [NSTG+1][NPT];

    assign x_re = '{
        butt16_real0,  butt16_real1,  butt16_real2,  butt16_real3,
        butt16_real4,  butt16_real5,  butt16_real6,  butt16_real7,
        butt16_real8,  butt16_real9,  butt16_real10, butt16_real11,
        butt16_real12, butt16_real13, butt16_real14, butt16_real15
    };

    assign x_im = '{
        butt16_imag0,  butt16_imag1,  butt16_imag2,  butt16_imag3,
        butt16_imag4,  butt16_imag5,  butt16_imag6,  butt16_imag7,
        butt16_imag8,  butt16_imag9,  butt16_imag10, butt16_imag11,
        butt16_imag12, butt16_imag13, butt16_imag14, butt16_imag15
    };

    // Bank 0 takes inputs in bit-reversed order; banks 1..4 take stage outputs
    always_comb begin
        for (int i = 0; i < NPT; i++) begin
            pipe_re_d[0][i] = x_re[bitrev4(4'(i))];
            pipe_im_d[0][i] = x_im[bitrev4(4'(i))];
        end
        for (int s = 0; s < NSTG; s++) begin
            pipe_re_d[s+1] = bf_re[s];
            pipe_im_d[s+1] = bf_im[s];
        end
    end

    // Pipeline banks, cleared asynchronously so in-flight vectors vanish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= NSTG; s++) begin
                for (int i = 0; i < NPT; i++) begin
                    pipe_re_q[s][i] <= '0;
                    pipe_im_q[s][i] <= '0;
                end
            end
        end else begin
            pipe_re_q <= pipe_re_d;
            pipe_im_q <= pipe_im_d;
        end
    end

    // Stage s pairs (top, top+half) with twiddle index j * 16 / 2^(s+1)
    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        for (genvar b = 0; b < NPT / 2; b++) begin : g_bf
            localparam int HALF = 1 << s;
            localparam int J    = b % HALF;
            localparam int TOP  = (b / HALF) * 2 * HALF + J;
            localparam int BOT  = TOP + HALF;

            fft_butterfly #(
                .TWI (J << (NSTG - 1 - s))
            ) u_bf (
                .a_re  (pipe_re_q[s][TOP]),
                .a_im  (pipe_im_q[s][TOP]),
                .b_re  (pipe_re_q[s][BOT]),
                .b_im  (pipe_im_q[s][BOT]),
                .y0_re (bf_re[s][TOP]),
                .y0_im (bf_im[s][TOP]),
                .y1_re (bf_re[s][BOT]),
                .y1_im (bf_im[s][BOT])
            );
        end
    end

    assign y0_real_fin  = pipe_re_q[NSTG][0];
    assign y1_real_fin  = pipe_re_q[NSTG][1];
    assign y2_real_fin  = pipe_re_q[NSTG][2];
    assign y3_real_fin  = pipe_re_q[NSTG][3];
    assign y4_real_fin  = pipe_re_q[NSTG][4];
    assign y5_real_fin  = pipe_re_q[NSTG][5];
    assign y6_real_fin  = pipe_re_q[NSTG][6];
    assign y7_real_fin  = pipe_re_q[NSTG][7];
    assign y8_real_fin  = pipe_re_q[NSTG][8];
    assign y9_real_fin  = pipe_re_q[NSTG][9];
    assign y10_real_fin = pipe_re_q[NSTG][10];
    assign y11_real_fin = pipe_re_q[NSTG][11];
    assign y12_real_fin = pipe_re_q[NSTG][12];
    assign y13_real_fin = pipe_re_q[NSTG][13];
    assign y14_real_fin = pipe_re_q[NSTG][14];
    assign y15_real_fin = pipe_re_q[NSTG][15];
    assign y0_imag_fin  = pipe_im_q[NSTG][0];
    assign y1_imag_fin  = pipe_im_q[NSTG][1];
    assign y2_imag_fin  = pipe_im_q[NSTG][2];
    assign y3_imag_fin  = pipe_im_q[NSTG][3];
    assign y4_imag_fin  = pipe_im_q[NSTG][4];
    assign y5_imag_fin  = pipe_im_q[NSTG][5];
    assign y6_imag_fin  = pipe_im_q[NSTG][6];
    assign y7_imag_fin  = pipe_im_q[NSTG][7];
    assign y8_imag_fin  = pipe_im_q[NSTG][8];
    assign y9_imag_fin  = pipe_im_q[NSTG][9];
    assign y10_imag_fin = pipe_im_q[NSTG][10];
    assign y11_imag_fin = pipe_im_q[NSTG][11];
    assign y12_imag_fin = pipe_im_q[NSTG][12];
    assign y13_imag_fin = pipe_im_q[NSTG][13];
    assign y14_imag_fin = pipe_im_q[NSTG][14];
    assign y15_imag_fin = pipe_im_q[NSTG][15];

endmodule

// File: tb/tb_fft_1.sv
// tb_fft_1: directed-vector bench for the 16-point pipelined FFT.
// Expected spectra are hand-derived constants; outputs sampled 1ns after posedge.
module tb_fft_1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] xr [16];
    logic [23:0] xi [16];
    logic [23:0] yr [16];
    logic [23:0] yi [16];

    int n_tests = 0;
    int n_fail  = 0;

    int tw_re [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
    int tw_im [8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};
    int p8_im [16] = '{0, 0, 19, 0, 8, 0, 3, 0, 0, 0, -3, 0, -8, 0, -19, 0};

    always #5 clk = ~clk;

    fft_1 dut (
        .clk           (clk),
        .rst           (rst),
        .butt16_real0  (xr[0]),
        .butt16_real1  (xr[1]),
        .butt16_real2  (xr[2]),
        .butt16_real3  (xr[3]),
        .butt16_real4  (xr[4]),
        .butt16_real5  (xr[5]),
        .butt16_real6  (xr[6]),
        .butt16_real7  (xr[7]),
        .butt16_real8  (xr[8]),
        .butt16_real9  (xr[9]),
        .butt16_real10 (xr[10]),
        .butt16_real11 (xr[11]),
        .butt16_real12 (xr[12]),
        .butt16_real13 (xr[13]),
        .butt16_real14 (xr[14]),
        .butt16_real15 (xr[15]),
        .butt16_imag0  (xi[0]),
        .butt16_imag1  (xi[1]),
        .butt16_imag2  (xi[2]),
        .butt16_imag3  (xi[3]),
        .butt16_imag4  (xi[4]),
        .butt16_imag5  (xi[5]),
        .butt16_imag6  (xi[6]),
        .butt16_imag7  (xi[7]),
        .butt16_imag8  (xi[8]),
        .butt16_imag9  (xi[9]),
        .butt16_imag10 (xi[10]),
        .butt16_imag11 (xi[11]),
        .butt16_imag12 (xi[12]),
        .butt16_imag13 (xi[13]),
        .butt16_imag14 (xi[14]),
        .butt16_imag15 (xi[15]),
        .y0_real_fin   (yr[0]),
        .y1_real_fin   (yr[1]),
        .y2_real_fin   (yr[2]),
        .y3_real_fin   (yr[3]),
        .y4_real_fin   (yr[4]),
        .y5_real_fin   (yr[5]),
        .y6_real_fin   (yr[6]),
        .y7_real_fin   (yr[7]),
        .y8_real_fin   (yr[8]),
        .y9_real_fin   (yr[9]),
        .y10_real_fin  (yr[10]),
        .y11_real_fin  (yr[11]),
        .y12_real_fin  (yr[12]),
        .y13_real_fin  (yr[13]),
        .y14_real_fin  (yr[14]),
        .y15_real_fin  (yr[15]),
        .y0_imag_fin   (yi[0]),
        .y1_imag_fin   (yi[1]),
        .y2_imag_fin   (yi[2]),
        .y3_imag_fin   (yi[3]),
        .y4_imag_fin   (yi[4]),
        .y5_imag_fin   (yi[5]),
        .y6_imag_fin   (yi[6]),
        .y7_imag_fin   (yi[7]),
        .y8_imag_fin   (yi[8]),
        .y9_imag_fin   (yi[9]),
        .y10_imag_fin  (yi[10]),
        .y11_imag_fin  (yi[11]),
        .y12_imag_fin  (yi[12]),
        .y13_imag_fin  (yi[13]),
        .y14_imag_fin  (yi[14]),
        .y15_imag_fin  (yi[15])
    );

    task automatic zero_in();
        for (int i = 0; i < 16; i++) begin
            xr[i] = '0;
            xi[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            xr[i] = 24'h000123;
            xi[i] = 24'h000456;
        end
        tick();
        tick();
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (yr[k] !== 24'd0 || yi[k] !== 24'd0) begin
                n_fail++;
                $display("FAIL reset X[%0d] got re=%0d im=%0d want 0", k, $signed(yr[k]), $signed(yi[k]));
            end
        end
        zero_in();
        #3 rst = 1'b0;
    endtask

    task automatic test_impulse();
        int er;
        int ei;
        xr[0] = 24'd1;
        tick();
        xr[0] = 24'(-4);
        xi[0] = 24'(-3);
        tick();
        zero_in();
        tick();
        tick();
        n_tests++;
        if (yr[0] !== 24'd0) begin
            n_fail++;
            $display("FAIL impulse_early X[0] got re=%0d want 0", $signed(yr[0]));
        end
        for (int v = 0; v < 2; v++) begin
            tick();
            er = (v == 0) ? 1 : -4;
            ei = (v == 0) ? 0 : -3;
            for (int k = 0; k < 16; k++) begin
                n_tests++;
                if ($signed(yr[k]) !== er || $signed(yi[k]) !== ei) begin
                    n_fail++;
                    $display("FAIL impulse%0d X[%0d] got re=%0d im=%0d want re=%0d im=%0d",
                             v, k, $signed(yr[k]), $signed(yi[k]), er, ei);
                end
            end
        end
    endtask

    task automatic test_dc();
        int er;
        for (int i = 0; i < 16; i++) xr[i] = 24'd1;
        tick();
        zero_in();
        repeat (3) tick();
        tick();
        for (int k = 0; k < 16; k++) begin
            er = (k == 0) ? 16 : 0;
            n_tests++;
            if ($signed(yr[k]) !== er || yi[k] !== 24'd0) begin
                n_fail++;
                $display("FAIL dc X[%0d] got re=%0d im=%0d want re=%0d im=0",
                         k, $signed(yr[k]), $signed(yi[k]), er);
            end
        end
    endtask

    task automatic test_twiddle();
        int er;
        int ei;
        xr[1] = 24'd16384;
        tick();
        zero_in();
        repeat (4) tick();
        for (int k = 0; k < 16; k++) begin
            er = (k < 8) ? tw_re[k % 8] : -tw_re[k % 8];
            ei = (k < 8) ? tw_im[k % 8] : -tw_im[k % 8];
            n_tests++;
            if ($signed(yr[k]) !== er || $signed(yi[k]) !== ei) begin
                n_fail++;
                $display("FAIL twiddle X[%0d] got re=%0d im=%0d want re=%0d im=%0d",
                         k, $signed(yr[k]), $signed(yi[k]), er, ei);
            end
        end
    endtask

    task automatic test_back_to_back();
        int er;
        int ei;
        int dr;
        int di;
        for (int i = 0; i < 16; i++) xr[i] = 24'((i % 4) + 1);
        tick();
        for (int i = 0; i < 16; i++) xr[i] = 24'((i % 8) + 1);
        tick();
        zero_in();
        tick();
        tick();
        n_tests++;
        if (yr[0] !== 24'd0) begin
            n_fail++;
            $display("FAIL b2b_early X[0] got re=%0d want 0", $signed(yr[0]));
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            er = 0;
            ei = 0;
            if (k == 0) er = 40;
            if (k == 4) begin er = -8; ei = 8; end
            if (k == 8) er = -8;
            if (k == 12) begin er = -8; ei = -8; end
            dr = $signed(yr[k]) - er;
            di = $signed(yi[k]) - ei;
            n_tests++;
            if (dr > 2 || dr < -2 || di > 2 || di < -2) begin
                n_fail++;
                $display("FAIL period4 X[%0d] got re=%0d im=%0d want re=%0d im=%0d",
                         k, $signed(yr[k]), $signed(yi[k]), er, ei);
            end
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            er = (k == 0) ? 72 : ((k % 2 == 0) ? -8 : 0);
            ei = p8_im[k];
            dr = $signed(yr[k]) - er;
            di = $signed(yi[k]) - ei;
            n_tests++;
            if (dr > 2 || dr < -2 || di > 2 || di < -2) begin
                n_fail++;
                $display("FAIL period8 X[%0d] got re=%0d im=%0d want re=%0d im=%0d",
                         k, $signed(yr[k]), $signed(yi[k]), er, ei);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) xr[i] = 24'h7FFFFF;
        tick();
        zero_in();
        repeat (4) tick();
        n_tests++;
        if (yr[0] !== 24'hFFFFF0 || yi[0] !== 24'd0) begin
            n_fail++;
            $display("FAIL overflow X[0] got re=%h im=%h want re=fffff0 im=0", yr[0], yi[0]);
        end
        n_tests++;
        if (yr[1] !== 24'd0 || yi[1] !== 24'd0) begin
            n_fail++;
            $display("FAIL overflow X[1] got re=%h im=%h want 0", yr[1], yi[1]);
        end
        n_tests++;
        if (yr[8] !== 24'd0 || yi[8] !== 24'd0) begin
            n_fail++;
            $display("FAIL overflow X[8] got re=%h im=%h want 0", yr[8], yi[8]);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 16; i++) xr[i] = 24'd1;
        repeat (5) tick();
        n_tests++;
        if (yr[0] !== 24'd16) begin
            n_fail++;
            $display("FAIL rst_pre X[0] got re=%0d want 16", $signed(yr[0]));
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (yr[k] !== 24'd0 || yi[k] !== 24'd0) begin
                n_fail++;
                $display("FAIL rst_async X[%0d] got re=%0d im=%0d want 0", k, $signed(yr[k]), $signed(yi[k]));
            end
        end
        tick();
        tick();
        n_tests++;
        if (yr[0] !== 24'd0) begin
            n_fail++;
            $display("FAIL rst_hold X[0] got re=%0d want 0", $signed(yr[0]));
        end
        zero_in();
        #3 rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) xr[i] = 24'd1;
        tick();
        zero_in();
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_tests++;
            if (yr[0] !== 24'd0) begin
                n_fail++;
                $display("FAIL rst_release edge%0d X[0] got re=%0d want 0", e, $signed(yr[0]));
            end
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if ($signed(yr[k]) !== ((k == 0) ? 16 : 0) || yi[k] !== 24'd0) begin
                n_fail++;
                $display("FAIL rst_dc X[%0d] got re=%0d im=%0d want re=%0d im=0",
                         k, $signed(yr[k]), $signed(yi[k]), (k == 0) ? 16 : 0);
            end
        end
    endtask

    initial begin
        zero_in();
        test_reset();
        test_impulse();
        test_dc();
        test_twiddle();
        test_back_to_back();
        test_overflow();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
